chunked_adder: RTL

CHUNKED_ADDER -- requirements
Module: chunked_adder

---
 rtl/chunked_adder_pkg.sv | 13 +
 rtl/chunked_adder_rca.sv | 34 +++
 rtl/chunked_adder.sv | 119 +++++++++++
 3 files changed

// File: rtl/chunked_adder_pkg.sv
// Shared definitions for the chunked (multi-cycle) ripple-carry adder:
// FSM state encodings and the state-register width.
package chunked_adder_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/chunked_adder_rca.sv
// Combinational CHUNK-bit ripple-carry adder used one slice at a time by chunked_adder.
// Carry-into-MSB output only exists when CHUNKED_ADDER_OVF_EN is defined.
module chunk_rca #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             cmsb
`endif
);

    logic [CHUNK:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[CHUNK];
`ifdef CHUNKED_ADDER_OVF_EN
    assign cmsb = c[CHUNK-1];
`endif

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder/subtractor: adds CHUNK bits per cycle LSB-first, valid/ready handshakes.
// Optional two's-complement overflow output enabled by macro CHUNKED_ADDER_OVF_EN.
module chunked_adder
    import chunked_adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CHUNKED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] a_r, b_r, sum_r;
    logic             carry, cout_r;
    logic [CHUNK-1:0] sl_a, sl_b, sl_s;
    logic             sl_c;
    logic             last;

    assign last = (cnt == CNT_W'(NCHUNK - 1));
    assign sl_a = a_r[cnt*CHUNK +: CHUNK];
    assign sl_b = b_r[cnt*CHUNK +: CHUNK];

`ifdef CHUNKED_ADDER_OVF_EN
    logic sl_cmsb;
    logic ovf_r;
`endif

    chunk_rca #(.CHUNK(CHUNK)) u_rca (
        .a    (sl_a),
        .b    (sl_b),
        .cin  (carry),
        .s    (sl_s),
        .cout (sl_c)
`ifdef CHUNKED_ADDER_OVF_EN
        ,
        .cmsb (sl_cmsb)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // in_ready is gated by rst so it reads 0 for the whole reset pulse.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) state_nx = RUN;
            end
            RUN:     if (last) state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Subtract is a + ~b + ~cin, so borrow-in becomes an inverted carry-in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            carry  <= 1'b0;
            a_r    <= '0;
            b_r    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
`ifdef CHUNKED_ADDER_OVF_EN
            ovf_r  <= 1'b0;
`endif
        end else if (state == IDLE && in_valid) begin
            a_r   <= a;
            b_r   <= sub ? ~b : b;
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            sum_r[cnt*CHUNK +: CHUNK] <= sl_s;
            carry <= sl_c;
            cnt   <= last ? '0 : cnt + CNT_W'(1);
            if (last) begin
                cout_r <= sl_c;
`ifdef CHUNKED_ADDER_OVF_EN
                ovf_r  <= sl_c ^ sl_cmsb;
`endif
            end
        end
    end

    assign sum  = sum_r;
    assign cout = cout_r;
`ifdef CHUNKED_ADDER_OVF_EN
    assign ovf  = ovf_r;
`endif

endmodule
